// File: rtl/rng_scheduler.sv
// Shared 32-bit XNOR LFSR random source, handed out one word per grant
// to NUM_REQ requesters in round-robin order after a warm-up period.
module rng_scheduler #(
  parameter int          NUM_REQ       = 4,
  parameter int          RNG_BIT_WIDTH = 32,
  parameter logic [31:0] SEED          = 32'h21B0C781,
  parameter int          WARMUP_CYCLES = 16
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     seed_load,
  input  logic [31:0]              seed_data,
  input  logic [NUM_REQ-1:0]       req,
  output logic [NUM_REQ-1:0]       grant,
  output logic                     rnd_valid,
  output logic [RNG_BIT_WIDTH-1:0] rnd_data,
  output logic                     ready
);

  localparam int PTR_W = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
  localparam logic [7:0] WARM_LAST = 8'(WARMUP_CYCLES - 1);
  localparam logic [31:0] LOCKUP = 32'hFFFF_FFFF;

  typedef enum logic [0:0] {
    WARMUP = 1'b0,
    SERVE  = 1'b1
  } state_t;

  state_t                   state_r;
  state_t                   state_nxt_s;
  logic [31:0]              lfsr_r;
  logic [7:0]               warm_cnt_r;
  logic [PTR_W-1:0]         rr_ptr_r;
  logic [NUM_REQ-1:0]       grant_r;
  logic                     rnd_valid_r;
  logic [RNG_BIT_WIDTH-1:0] rnd_data_r;
  logic                     found_s;
  logic [PTR_W-1:0]         winner_s;
  logic [PTR_W-1:0]         ptr_nxt_s;
  logic [31:0]              seed_safe_s;

  // XNOR taps 32,22,2,1; the all-ones word is the only lockup state.
  function automatic logic [31:0] lfsr_step(input logic [31:0] s);
    return {s[30:0], ~(s[31] ^ s[21] ^ s[1] ^ s[0])};
  endfunction

  // Round-robin search: first set request at or above rr_ptr, wrapping.
  always_comb begin
    found_s  = 1'b0;
    winner_s = '0;
    for (int k = 0; k < NUM_REQ; k++) begin
      int idx;
      idx = (int'(rr_ptr_r) + k) % NUM_REQ;
      if (!found_s && req[PTR_W'(idx)]) begin
        found_s  = 1'b1;
        winner_s = PTR_W'(idx);
      end else begin
        found_s  = found_s;
      end
    end
  end

  // Pointer advance past the winner and lockup-safe reseed value.
  always_comb begin
    ptr_nxt_s   = '0;
    seed_safe_s = seed_data;
    if (int'(winner_s) == NUM_REQ - 1) begin
      ptr_nxt_s = '0;
    end else begin
      ptr_nxt_s = winner_s + {{(PTR_W-1){1'b0}}, 1'b1};
    end
    if (seed_data == LOCKUP) begin
      seed_safe_s = SEED;
    end else begin
      seed_safe_s = seed_data;
    end
  end

  // FSM next state: warm-up ends on its last counted advance.
  always_comb begin
    state_nxt_s = state_r;
    case (state_r)
      WARMUP: begin
        if (warm_cnt_r == WARM_LAST) begin
          state_nxt_s = SERVE;
        end else begin
          state_nxt_s = WARMUP;
        end
      end
      SERVE:   state_nxt_s = SERVE;
      default: state_nxt_s = WARMUP;
    endcase
  end

  // All state: reset beats reseed beats normal stepping and granting.
  always_ff @(posedge clk) begin
    if (rst) begin
      lfsr_r      <= SEED;
      state_r     <= WARMUP;
      warm_cnt_r  <= 8'd0;
      rr_ptr_r    <= '0;
      grant_r     <= '0;
      rnd_valid_r <= 1'b0;
      rnd_data_r  <= '0;
    end else if (seed_load) begin
      lfsr_r      <= seed_safe_s;
      state_r     <= WARMUP;
      warm_cnt_r  <= 8'd0;
      grant_r     <= '0;
      rnd_valid_r <= 1'b0;
    end else begin
      lfsr_r  <= lfsr_step(lfsr_r);
      state_r <= state_nxt_s;
      if (state_r == WARMUP) begin
        warm_cnt_r <= warm_cnt_r + 8'd1;
      end else begin
        warm_cnt_r <= warm_cnt_r;
      end
      if (state_r == SERVE && found_s) begin
        grant_r     <= {{(NUM_REQ-1){1'b0}}, 1'b1} << winner_s;
        rnd_valid_r <= 1'b1;
        rnd_data_r  <= lfsr_r[RNG_BIT_WIDTH-1:0];
        rr_ptr_r    <= ptr_nxt_s;
      end else begin
        grant_r     <= '0;
        rnd_valid_r <= 1'b0;
      end
    end
  end

  assign grant     = grant_r;
  assign rnd_valid = rnd_valid_r;
  assign rnd_data  = rnd_data_r;
  assign ready     = (state_r == SERVE);

endmodule

// File: doc/rng_scheduler.md
RNG_SCHEDULER -- requirements
Module: rng_scheduler

Interface
REQ-001 The module SHALL have parameter NUM_REQ, default 4, giving the number of requesters sharing the random source; legal range 2..16.
REQ-002 The module SHALL have parameter RNG_BIT_WIDTH, default 32, giving the width of the delivered random word; legal range 1..32.
REQ-003 The module SHALL have parameter SEED, 32 bits, default 32'h21B0C781, giving the reset and fallback LFSR state.
REQ-004 The module SHALL have parameter WARMUP_CYCLES, default 16, giving the number of LFSR advances before service starts; legal range 1..255.
REQ-005 The module SHALL have port clk, input, 1 bit: the single clock; all state updates on its rising edge.
REQ-006 The module SHALL have port rst, input, 1 bit: reset, synchronous, active-high.
REQ-007 The module SHALL have port seed_load, input, 1 bit: reseed strobe.
REQ-008 The module SHALL have port seed_data, input, 32 bits: new LFSR state, sampled when seed_load=1.
REQ-009 The module SHALL have port req, input, NUM_REQ bits: per-requester level request for one random word.
REQ-010 The module SHALL have port grant, output, NUM_REQ bits: registered, one-hot or zero; grant[i]=1 delivers rnd_data to requester i.
REQ-011 The module SHALL have port rnd_valid, output, 1 bit: registered, equals OR of grant.
REQ-012 The module SHALL have port rnd_data, output, RNG_BIT_WIDTH bits: registered random word.
REQ-013 The module SHALL have port ready, output, 1 bit: 1 exactly when the FSM is in SERVE.

Function
REQ-014 The block SHALL contain one 32-bit Fibonacci LFSR, lfsr[31:0], with step next = {lfsr[30:0], fb}, where fb = NOT(lfsr[31] XOR lfsr[21] XOR lfsr[1] XOR lfsr[0]) (XNOR taps 32,22,2,1).
REQ-015 The LFSR lockup state SHALL be 32'hFFFFFFFF; that value SHALL never be loaded.
REQ-016 The FSM SHALL have exactly two states: WARMUP and SERVE.
REQ-017 In WARMUP, the LFSR SHALL advance every cycle; warm_cnt SHALL increment; on the edge where warm_cnt == WARMUP_CYCLES-1 the state SHALL become SERVE; net effect: exactly WARMUP_CYCLES advances.
REQ-018 In WARMUP, req SHALL be ignored (not queued); grant=0; rnd_valid=0.
REQ-019 In SERVE, the LFSR SHALL advance every cycle, whether or not a grant is issued.
REQ-020 In SERVE with req != 0, the winner SHALL be the first set bit of req, searching upward from rr_ptr and wrapping from NUM_REQ-1 to 0.
REQ-021 On the next edge after a SERVE win: grant <= one-hot(winner); rnd_valid <= 1; rnd_data <= pre-advance lfsr[RNG_BIT_WIDTH-1:0]; rr_ptr <= (winner+1) mod NUM_REQ.
REQ-022 Latency SHALL be one cycle from req sampled to grant.
REQ-023 Each grant SHALL be a single-cycle pulse per word; a requester holding req high receives one word per win.
REQ-024 Two consecutive grants SHALL always carry distinct successive LFSR states.
REQ-025 With all NUM_REQ requests held high, grants SHALL rotate 0,1,..,NUM_REQ-1,0,... back-to-back with no idle cycle.
REQ-026 In SERVE with req == 0: grant <= 0; rnd_valid <= 0; rnd_data holds its value; rr_ptr holds.
REQ-027 When seed_load=1 and rst=0, at the edge: lfsr <= seed_data, or SEED if seed_data == 32'hFFFFFFFF; state <= WARMUP; warm_cnt <= 0; grant <= 0; rnd_valid <= 0; rr_ptr unchanged; rnd_data holds.
REQ-028 seed_load SHALL apply from either state and SHALL abort any warm-up in progress.
REQ-029 A request present in the same cycle as seed_load SHALL be dropped.
REQ-030 Priority SHALL be: rst > seed_load > normal operation.

Reset
REQ-031 While rst=1 at an edge: lfsr <= SEED; state <= WARMUP; warm_cnt <= 0; rr_ptr <= 0; grant <= 0; rnd_valid <= 0; rnd_data <= 0; ready = 0.
REQ-032 Reset mid-grant SHALL clear grant and rnd_valid on that edge; the following cycle SHALL show no grant.

Verification
REQ-033 Reset sequence: WARMUP_CYCLES=1, RNG_BIT_WIDTH=32; rst for 2 cycles, then req=4'b0001 -> ready=1 one cycle after reset release; next cycle grant=4'b0001, rnd_data=32'h43618F03, rnd_valid=1.
REQ-034 Round-robin fairness: req=4'b1111 held for 8 SERVE cycles -> grant sequence 0001,0010,0100,1000,0001,0010,0100,1000, with no zero cycles and all eight rnd_data values distinct.
REQ-035 Pointer wrap and skip: after a grant to requester 3, req=4'b0101 -> grant 0001, then 0100, then 0001.
REQ-036 Reseed: seed_load=1, seed_data=32'h21B0C781 during SERVE with req=4'b1111 -> grant=0 and ready=0 for exactly WARMUP_CYCLES cycles, then service resumes; with WARMUP_CYCLES=1 the first rnd_data=32'h43618F03.
REQ-037 Lockup guard: seed_load with seed_data=32'hFFFFFFFF -> behaviour identical to seed_data=SEED; rnd_data never equals 32'hFFFFFFFF.
REQ-038 Idle and warm-up: req=4'b1111 during WARMUP -> no grant until ready=1; in SERVE, req=0 -> rnd_valid=0 and rnd_data unchanged.
